// File: rtl/seven_seg_pkg.sv
// Shared types and active-low segment patterns ({g,f,e,d,c,b,a}) for the scan driver.
package seven_seg_pkg;

    localparam int unsigned SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_MINUS = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_E     = 7'h06;

    typedef logic [1:0] digit_idx_t;

    localparam digit_idx_t IDX_SIGN     = 2'd3;
    localparam digit_idx_t IDX_HUNDREDS = 2'd2;
    localparam digit_idx_t IDX_TENS     = 2'd1;
    localparam digit_idx_t IDX_UNITS    = 2'd0;

    typedef enum logic {ST_BLANK, ST_LIT} slot_state_t;

    typedef struct packed {
        logic       sign;
        logic [3:0] hundreds;
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_value_t;

    // Non-BCD codes 10..15 render as 'E'.
    function automatic logic [SEG_W-1:0] digit_pattern(input logic [3:0] bcd);
        case (bcd)
            4'd0:    digit_pattern = 7'h40;
            4'd1:    digit_pattern = 7'h79;
            4'd2:    digit_pattern = 7'h24;
            4'd3:    digit_pattern = 7'h30;
            4'd4:    digit_pattern = 7'h19;
            4'd5:    digit_pattern = 7'h12;
            4'd6:    digit_pattern = 7'h02;
            4'd7:    digit_pattern = 7'h78;
            4'd8:    digit_pattern = 7'h00;
            4'd9:    digit_pattern = 7'h10;
            default: digit_pattern = SEG_E;
        endcase
    endfunction

endpackage

// File: rtl/bcd_to_seven_seg.sv
// Combinational BCD to active-low 7-segment decoder with a blank override.
module bcd_to_seven_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0]       bcd,
    input  logic             blank,
    output logic [SEG_W-1:0] pattern_c
);

    always_comb begin
        pattern_c = blank ? SEG_BLANK : digit_pattern(bcd);
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexes sign/hundreds/tens/units onto a 4-digit common-anode display,
// latching new values only at frame boundaries.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int unsigned DIV   = 50000,
    parameter int unsigned BLANK = 500,
    parameter int unsigned LZB   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       load,
    input  logic       sign,
    input  logic [3:0] hundreds,
    input  logic [3:0] tens,
    input  logic [3:0] units,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       frame_start
);

    localparam int unsigned CW = $clog2(DIV);

    logic [CW-1:0]    cnt;
    digit_idx_t       idx;
    slot_state_t      state;
    bcd_value_t       shadow;
    bcd_value_t       disp;
    bcd_value_t       in_value;
    logic             pending;

    logic             wrap_c;
    logic             frame_end_c;
    logic [3:0]       mux_bcd_c;
    logic             mux_blank_c;
    logic [SEG_W-1:0] dec_seg_c;
    logic [SEG_W-1:0] seg_next_c;
    logic [3:0]       an_next_c;

    assign in_value    = bcd_value_t'({sign, hundreds, tens, units});
    assign wrap_c      = (cnt == CW'(DIV - 1));
    assign frame_end_c = en && wrap_c && (idx == IDX_UNITS);

    // Select the digit for the current slot and apply leading-zero blanking.
    always_comb begin
        mux_bcd_c   = disp.units;
        mux_blank_c = 1'b0;
        case (idx)
            IDX_HUNDREDS: begin
                mux_bcd_c   = disp.hundreds;
                mux_blank_c = (LZB != 0) && (disp.hundreds == 4'd0);
            end
            IDX_TENS: begin
                mux_bcd_c   = disp.tens;
                mux_blank_c = (LZB != 0) && (disp.hundreds == 4'd0) && (disp.tens == 4'd0);
            end
            default: ;
        endcase
    end

    bcd_to_seven_seg u_dec (
        .bcd       (mux_bcd_c),
        .blank     (mux_blank_c),
        .pattern_c (dec_seg_c)
    );

    always_comb begin
        seg_next_c = dec_seg_c;
        if (idx == IDX_SIGN) begin
            seg_next_c = disp.sign ? SEG_MINUS : SEG_BLANK;
        end
        an_next_c = ~(4'b0001 << idx);
    end

    // Slot counter, digit index, BLANK/LIT slot FSM and registered display outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= IDX_SIGN;
            state       <= ST_BLANK;
            an          <= 4'hF;
            seg         <= SEG_BLANK;
            frame_start <= 1'b0;
        end else if (!en) begin
            an          <= 4'hF;
            seg         <= SEG_BLANK;
            frame_start <= 1'b0;
        end else begin
            frame_start <= (cnt == '0) && (idx == IDX_SIGN);
            if (state == ST_LIT) begin
                an  <= an_next_c;
                seg <= seg_next_c;
            end else begin
                an  <= 4'hF;
                seg <= SEG_BLANK;
            end
            if (wrap_c) begin
                cnt   <= '0;
                idx   <= idx - 2'd1;
                state <= ST_BLANK;
            end else begin
                cnt <= cnt + CW'(1);
                if (cnt == CW'(BLANK - 1)) begin
                    state <= ST_LIT;
                end
            end
        end
    end

    // A load coinciding with the frame end bypasses the shadow and leaves nothing pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow  <= '0;
            disp    <= '0;
            pending <= 1'b0;
        end else if (frame_end_c) begin
            if (load) begin
                disp <= in_value;
            end else if (pending) begin
                disp <= shadow;
            end
            pending <= 1'b0;
        end else if (load) begin
            shadow  <= in_value;
            pending <= 1'b1;
        end
    end

endmodule
